// File: rtl/peripheral_dsa_pkg.sv
// Shared DSA constants, word type and stack operation decode.
package peripheral_dsa_pkg;

    localparam int DATA_SIZE = 512;
    localparam int STACK_ADDRESS_SIZE = 4;

    typedef logic [DATA_SIZE-1:0] word_t;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_PUSH,
        OP_POP,
        OP_EXCHANGE
    } stack_op_e;

endpackage

// File: rtl/peripheral_dsa_stack_ram.sv
// Single-port stack RAM, registered read-before-write output.
module peripheral_dsa_stack_ram #(
    parameter int DATA_SIZE    = 512,
    parameter int ADDRESS_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic                    re,
    input  logic [ADDRESS_SIZE-1:0] addr,
    input  logic [DATA_SIZE-1:0]    wdata,
    output logic [DATA_SIZE-1:0]    rdata
);

    localparam int DEPTH = 2 ** ADDRESS_SIZE;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [DATA_SIZE-1:0] rdata_d;
    logic [DATA_SIZE-1:0] rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/peripheral_dsa_stack.sv
// LIFO stack for DSA engines; PERIPHERAL_DSA_STACK_ERROR_EN adds
// sticky OVERFLOW/UNDERFLOW flags with a synchronous CLEAR.
module peripheral_dsa_stack #(
    parameter int DATA_SIZE    = peripheral_dsa_pkg::DATA_SIZE,
    parameter int ADDRESS_SIZE = peripheral_dsa_pkg::STACK_ADDRESS_SIZE
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    PUSH,
    input  logic                    POP,
    input  logic [DATA_SIZE-1:0]    DATA_IN,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic                    DATA_OUT_ENABLE,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic [ADDRESS_SIZE:0]   COUNT
`ifdef PERIPHERAL_DSA_STACK_ERROR_EN
    ,
    input  logic                    CLEAR,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
`endif
);

    import peripheral_dsa_pkg::*;

    localparam logic [ADDRESS_SIZE:0] DEPTH_W =
        {1'b1, {ADDRESS_SIZE{1'b0}}};
    localparam logic [ADDRESS_SIZE:0] SP_ONE =
        {{ADDRESS_SIZE{1'b0}}, 1'b1};
    localparam logic [ADDRESS_SIZE-1:0] ADDR_ONE =
        {{(ADDRESS_SIZE-1){1'b0}}, 1'b1};

    stack_op_e op;

    logic [ADDRESS_SIZE:0]   sp_d, sp_q;
    logic                    full_d, full_q;
    logic                    empty_d, empty_q;
    logic                    dout_en_d, dout_en_q;
    logic                    ram_we;
    logic                    ram_re;
    logic [ADDRESS_SIZE-1:0] ram_addr;
    logic [DATA_SIZE-1:0]    ram_rdata;

    // A push on an empty stack with POP also high degrades to a plain push.
    always_comb begin
        op = OP_NOP;
        unique case (1'b1)
            (PUSH && POP && !empty_q):
                op = OP_EXCHANGE;
            (PUSH && !full_q && (!POP || empty_q)):
                op = OP_PUSH;
            (POP && !PUSH && !empty_q):
                op = OP_POP;
            default:
                op = OP_NOP;
        endcase
    end

    always_comb begin
        sp_d     = sp_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = sp_q[ADDRESS_SIZE-1:0];
        case (op)
            OP_PUSH: begin
                ram_we = 1'b1;
                sp_d   = sp_q + SP_ONE;
            end
            OP_POP: begin
                ram_re   = 1'b1;
                ram_addr = sp_q[ADDRESS_SIZE-1:0] - ADDR_ONE;
                sp_d     = sp_q - SP_ONE;
            end
            OP_EXCHANGE: begin
                ram_re   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = sp_q[ADDRESS_SIZE-1:0] - ADDR_ONE;
            end
            default: begin
                sp_d = sp_q;
            end
        endcase
        dout_en_d = ram_re;
        full_d    = (sp_d == DEPTH_W);
        empty_d   = (sp_d == '0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sp_q      <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            dout_en_q <= 1'b0;
        end else begin
            sp_q      <= sp_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            dout_en_q <= dout_en_d;
        end
    end

    peripheral_dsa_stack_ram #(
        .DATA_SIZE    (DATA_SIZE),
        .ADDRESS_SIZE (ADDRESS_SIZE)
    ) u_ram (
        .clk   (CLK),
        .rst_n (RST),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (DATA_IN),
        .rdata (ram_rdata)
    );

    assign DATA_OUT        = ram_rdata;
    assign DATA_OUT_ENABLE = dout_en_q;
    assign FULL            = full_q;
    assign EMPTY           = empty_q;
    assign COUNT           = sp_q;

`ifdef PERIPHERAL_DSA_STACK_ERROR_EN
    logic overflow_d, overflow_q;
    logic underflow_d, underflow_q;

    always_comb begin
        overflow_d  = overflow_q | (PUSH && !POP && full_q);
        underflow_d = underflow_q | (POP && !PUSH && empty_q);
        if (CLEAR) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;
`endif

endmodule

// File: tb/tb_peripheral_dsa_stack.sv
// Directed self-checking bench for peripheral_dsa_stack.
module tb_peripheral_dsa_stack;

    import peripheral_dsa_pkg::*;

    localparam int AW = STACK_ADDRESS_SIZE;

    logic          CLK;
    logic          RST;
    logic          PUSH;
    logic          POP;
    word_t         DATA_IN;
    word_t         DATA_OUT;
    logic          DATA_OUT_ENABLE;
    logic          FULL;
    logic          EMPTY;
    logic [AW:0]   COUNT;
`ifdef PERIPHERAL_DSA_STACK_ERROR_EN
    logic          CLEAR;
    logic          OVERFLOW;
    logic          UNDERFLOW;
`endif

    int n_checks;
    int n_errors;

    peripheral_dsa_stack dut (
        .CLK             (CLK),
        .RST             (RST),
        .PUSH            (PUSH),
        .POP             (POP),
        .DATA_IN         (DATA_IN),
        .DATA_OUT        (DATA_OUT),
        .DATA_OUT_ENABLE (DATA_OUT_ENABLE),
        .FULL            (FULL),
        .EMPTY           (EMPTY),
        .COUNT           (COUNT)
`ifdef PERIPHERAL_DSA_STACK_ERROR_EN
        ,
        .CLEAR           (CLEAR),
        .OVERFLOW        (OVERFLOW),
        .UNDERFLOW       (UNDERFLOW)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic push, input logic pop, input int din);
        PUSH    = push;
        POP     = pop;
        DATA_IN = word_t'(din);
    endtask

    task automatic status(input string tag, input int cnt, input logic en);
        check({tag, ".count"}, word_t'(COUNT), word_t'(cnt));
        check({tag, ".en"}, word_t'(DATA_OUT_ENABLE), word_t'(en));
        check({tag, ".full"}, word_t'(FULL), word_t'(cnt == 16));
        check({tag, ".empty"}, word_t'(EMPTY), word_t'(cnt == 0));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST = 1'b1;
        drive(1'b0, 1'b0, 0);
`ifdef PERIPHERAL_DSA_STACK_ERROR_EN
        CLEAR = 1'b0;
`endif
        #2 RST = 1'b0;
        #1;
        status("rst", 0, 1'b0);
        check("rst.dout", DATA_OUT, '0);
        tick();
        tick();
        RST = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            status("idle", 0, 1'b0);
        end

        // push 1,2,3 then pop three
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, i);
            tick();
            status("push", i, 1'b0);
        end
        for (int i = 3; i >= 1; i--) begin
            drive(1'b0, 1'b1, 0);
            tick();
            status("pop", i - 1, 1'b1);
            check("pop.dout", DATA_OUT, word_t'(i));
        end
        drive(1'b0, 1'b0, 0);
        tick();
        status("pop.after", 0, 1'b0);
        check("pop.hold", DATA_OUT, word_t'(1));

        // fill to full, reject 17th push
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, i);
            tick();
        end
        status("fill", 16, 1'b0);
        drive(1'b1, 1'b0, 'hFF);
        tick();
        status("ovf", 16, 1'b0);
`ifdef PERIPHERAL_DSA_STACK_ERROR_EN
        check("ovf.flag", word_t'(OVERFLOW), word_t'(1));
`endif
        for (int i = 15; i >= 0; i--) begin
            drive(1'b0, 1'b1, 0);
            tick();
            check("drain.dout", DATA_OUT, word_t'(i));
            check("drain.en", word_t'(DATA_OUT_ENABLE), word_t'(1));
            check("drain.count", word_t'(COUNT), word_t'(i));
        end

        // pop on empty is dropped
        drive(1'b0, 1'b1, 0);
        tick();
        status("udf", 0, 1'b0);
        check("udf.hold", DATA_OUT, word_t'(0));
`ifdef PERIPHERAL_DSA_STACK_ERROR_EN
        check("udf.flag", word_t'(UNDERFLOW), word_t'(1));
        drive(1'b0, 1'b1, 0);
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        check("clr.udf", word_t'(UNDERFLOW), word_t'(0));
        check("clr.ovf", word_t'(OVERFLOW), word_t'(0));
`endif

        // exchange
        drive(1'b1, 1'b0, 'hA);
        tick();
        status("xchg.pre", 1, 1'b0);
        drive(1'b1, 1'b1, 'hB);
        tick();
        status("xchg", 1, 1'b1);
        check("xchg.dout", DATA_OUT, word_t'('hA));
        drive(1'b0, 1'b1, 0);
        tick();
        status("xchg.pop", 0, 1'b1);
        check("xchg.pop.dout", DATA_OUT, word_t'('hB));

        // push+pop on empty acts as a plain push
        drive(1'b1, 1'b1, 'hC);
        tick();
        status("pp.empty", 1, 1'b0);
        check("pp.hold", DATA_OUT, word_t'('hB));
        drive(1'b0, 1'b1, 0);
        tick();
        check("pp.pop", DATA_OUT, word_t'('hC));

        // async reset during a pop
        drive(1'b1, 1'b0, 'h11);
        tick();
        drive(1'b1, 1'b0, 'h22);
        tick();
        status("mid.pre", 2, 1'b0);
        drive(1'b0, 1'b1, 0);
        #2 RST = 1'b0;
        #1;
        status("mid.rst", 0, 1'b0);
        check("mid.dout", DATA_OUT, '0);
        tick();
        drive(1'b0, 1'b0, 0);
        #2 RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            status("mid.after", 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/peripheral_dsa_stack.md
Name: peripheral_dsa_stack

Overview:
- LIFO stack stage holding DATA_SIZE-wide words.
- Sits directly downstream of the DSA package constants and is the first storage block built on them.
- Feeds the DSA algorithm engines: they push operands and intermediate results, then pop them back in reverse order.
- Registered read path; push/pop are single-cycle request strobes with full/empty status.

Parameters:
- DATA_SIZE, 512 (from peripheral_dsa_pkg), word width in bits.
- ADDRESS_SIZE, 4, log2 of stack depth; DEPTH = 2**ADDRESS_SIZE = 16 entries.

Ports:
- CLK  input  1  single clock, all state on rising edge.
- RST  input  1  asynchronous, active-low reset.
- PUSH  input  1  push request, one word per cycle while high.
- POP  input  1  pop request, one word per cycle while high.
- DATA_IN  input  DATA_SIZE  word to push, sampled with PUSH.
- DATA_OUT  output  DATA_SIZE  popped word, registered.
- DATA_OUT_ENABLE  output  1  one-cycle strobe; DATA_OUT holds a valid popped word.
- FULL  output  1  COUNT == DEPTH.
- EMPTY  output  1  COUNT == 0.
- COUNT  output  ADDRESS_SIZE+1  current number of stored words.

Behaviour:
- Reset (RST low, asynchronous) values:
  - DATA_OUT = 0, DATA_OUT_ENABLE = 0, COUNT = 0, EMPTY = 1, FULL = 0.
  - The stack pointer is cleared.
  - Memory contents are not reset.
- Reset mid-operation aborts any in-flight pop. No DATA_OUT_ENABLE is produced after reset release for a request accepted before reset.
- Pointer SP = COUNT. The top entry is at address SP-1. Pointer arithmetic is ADDRESS_SIZE+1 bits and never wraps, because accepted operations are gated by FULL/EMPTY.
- Accepted push (PUSH=1, POP=0, FULL=0): write mem[SP] <= DATA_IN; SP <= SP+1.
- Accepted pop (POP=1, PUSH=0, EMPTY=0): DATA_OUT <= mem[SP-1]; DATA_OUT_ENABLE <= 1 in the next cycle (latency 1); SP <= SP-1.
- Simultaneous PUSH and POP:
  - EMPTY=0: exchange. DATA_OUT <= old top, DATA_OUT_ENABLE <= 1, mem[SP-1] <= DATA_IN, SP unchanged.
  - EMPTY=1: push only. No output strobe; SP <= 1.
- Push while FULL (without POP) is ignored. Contents and COUNT are unchanged.
- Pop while EMPTY (without PUSH) is ignored. DATA_OUT_ENABLE stays 0 and DATA_OUT holds its last value.
- DATA_OUT_ENABLE is 0 in every cycle without an accepted pop. DATA_OUT holds its value between pops.
- FULL, EMPTY and COUNT are registered and reflect state after the last edge. Status updates in the same cycle the pointer changes.
- Back-to-back operations at full rate are supported (one op per cycle, no bubbles).
- There is no FSM. State is the pointer plus the output register; the control decode is combinational over {PUSH, POP, FULL, EMPTY}.

Optional Feature:
- Macro: PERIPHERAL_DSA_STACK_ERROR_EN.
- When defined, the block adds:
  - Output OVERFLOW (1): sticky, set by a push rejected because FULL=1.
  - Output UNDERFLOW (1): sticky, set by a pop rejected because EMPTY=1.
  - Input CLEAR (1): synchronous; clears both flags, and has priority over a same-cycle set.
  - Both flags reset to 0.
- When not defined, these ports do not exist and rejected requests are silently dropped.

Decomposition:
- peripheral_dsa_pkg additions:
  - DATA_SIZE (existing).
  - STACK_ADDRESS_SIZE = 4.
  - Typedef of the DATA_SIZE-wide word.
  - Enum of the decoded operation (NOP, PUSH, POP, EXCHANGE) used by the control decode.
- Sub-module peripheral_dsa_stack_ram:
  - Single-port synchronous RAM, DEPTH x DATA_SIZE.
  - Write enable with registered read. Exchange reads and writes the same address; read-before-write is required.
  - The top level holds the pointer, decode and status.

Test Plan:
- Reset then idle: after RST release, EMPTY=1, FULL=0, COUNT=0, DATA_OUT_ENABLE=0 for 10 cycles with no requests.
- Push 0x1, 0x2, 0x3 in consecutive cycles, then pop 3 cycles: DATA_OUT = 0x3, 0x2, 0x1 on successive cycles, each with DATA_OUT_ENABLE=1 one cycle after its POP; COUNT goes 3→0, EMPTY=1 at end.
- Fill boundary:
  - Push 16 words 0..15: FULL=1, COUNT=16.
  - A 17th push of 0xFF is ignored, and OVERFLOW=1 if PERIPHERAL_DSA_STACK_ERROR_EN.
  - Next pop returns 15.
- Underflow: POP on empty stack produces no DATA_OUT_ENABLE and leaves COUNT=0 (UNDERFLOW=1 with macro); CLEAR then drops the flag to 0.
- Exchange: stack holds 0xA (COUNT=1); PUSH=POP=1 with DATA_IN=0xB gives DATA_OUT=0xA with strobe and COUNT=1; next pop returns 0xB.
- Reset mid-operation: assert RST low during the POP cycle of a 2-entry stack; no strobe afterwards, COUNT=0, EMPTY=1 immediately (asynchronous).
